mc_controller: RTL and testbench

Control unit for the RV32I multicycle datapath. It sequences fetch, decode, execute, memory and writeback over several cycles per instruction, using a Moore main state machine plus a combinational ALU decoder and immediate-source decoder. Each cycle it drives every mux select and write enable of the datapath. It consumes the instruction fields from the instruction register and the ALU zero flag.

---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 35 +++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the RV32I multicycle controller and datapath.
//   - state_e     : main FSM states
//   - OP_*        : supported opcodes
//   - ALU_*       : ALUControl encodings
//   - ALUOP_*     : ALUOp encodings (main FSM -> ALU decoder)
//   - RES_*       : ResultSrc mux selects
//   - SRCA_*/SRCB_*: ALU operand mux selects
//   - IMM_*       : ImmSrc encodings, imm_src() decodes them from the opcode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction fields to ALUControl.
//   alu_op_i      : 00 add, 01 sub, 10 decode funct3
//   funct3_i      : instr[14:12]
//   funct7b5_i    : instr[30]
//   op5_i         : instr[5], distinguishes R-type (sub allowed) from I-ALU
//   alu_control_o : ALU operation select
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // addi has no sub form, so instr[30] only counts for R-type
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for the RV32I multicycle datapath.
//   clk, reset           : clock, synchronous active-high reset
//   op, funct3, funct7b5 : fields from the instruction register
//   zero                 : ALU zero flag for the current cycle
//   PCWrite..RegWrite    : datapath mux selects and write enables
//   illegal_op           : one-cycle pulse in DECODE for an unsupported opcode
// Outputs are combinational from the state register and inputs; the state
// register is the only storage.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic       pc_update, branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes OldPC + imm here so BEQ can use the branch target
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (jump target from DECODE); ALU forms OldPC + 4 for rd
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts whatever is in flight: present FETCH selects, no writes.
    if (reset) begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      alu_op     = ALUOP_ADD;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = RES_ALURES;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_FOUR;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end

    PCWrite = (branch & zero) | pc_update;
  end

  assign ImmSrc = imm_src(op);

  alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. A driver issues whole
// instructions cycle by cycle and queues the expected control word for each
// cycle; a monitor pops and compares at every falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pcw, adr, memw, irw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       regw, ill;
  } ctl_t;

  typedef struct {
    ctl_t w;
    int   tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   instr_n = 0;

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic int n_cycles(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_rule(input logic [2:0] f3, input bit sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for cycle 'cyc' (1-based) of an instruction.
  function automatic ctl_t model(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input int cyc, input logic z,
                                 input bit rst);
    ctl_t w = '0;
    w.imm = imm_of(o);
    if (rst) begin
      w.rs = 2'b10; w.sb = 2'b10;
      return w;
    end
    if (cyc == 1) begin
      w.pcw = 1; w.irw = 1; w.rs = 2'b10; w.sb = 2'b10;
    end else if (cyc == 2) begin
      w.sa = 2'b01; w.sb = 2'b01; w.ill = !is_legal(o);
    end else begin
      case (o)
        7'b0000011, 7'b0100011: begin
          if (cyc == 3) begin w.sa = 2'b10; w.sb = 2'b01; end
          else if (cyc == 4) begin w.adr = 1; w.memw = (o == 7'b0100011); end
          else begin w.rs = 2'b01; w.regw = 1; end
        end
        7'b0110011, 7'b0010011: begin
          if (cyc == 3) begin
            w.sa = 2'b10;
            w.sb = (o == 7'b0110011) ? 2'b00 : 2'b01;
            w.alu = alu_rule(f3, o[5] & f7);
          end else w.regw = 1;
        end
        7'b1101111: begin
          if (cyc == 3) begin w.sa = 2'b01; w.sb = 2'b10; w.pcw = 1; end
          else w.regw = 1;
        end
        7'b1100011: begin
          w.sa = 2'b10; w.alu = 3'b001; w.pcw = z;
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = sb_q.pop_front();
      a = '{pcw: PCWrite, adr: AdrSrc, memw: MemWrite, irw: IRWrite,
            rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, imm: ImmSrc,
            alu: ALUControl, regw: RegWrite, ill: illegal_op};
      n_cmp++;
      if (a !== e.w) begin
        n_err++;
        $display("FAIL ctl instr%0d cyc%0d: got %b required %b (pcw adr memw irw rs sa sb imm alu regw ill)",
                 e.tag / 8, e.tag % 8, a, e.w);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push(input ctl_t w, input int cyc);
    exp_t e;
    e.w = w;
    e.tag = instr_n * 8 + cyc;
    sb_q.push_back(e);
  endtask

  // zmode: 0/1 fixed zero flag, 2 random each cycle. abort_at: cycle to assert reset (0 none).
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_at);
    int n;
    n = n_cycles(o);
    instr_n++;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      reset = 1'b0; op = o; funct3 = f3; funct7b5 = f7;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      if (c == abort_at) begin
        reset = 1'b1;
        push(model(o, f3, f7, c, zero, 1'b1), c);
        return;
      end
      push(model(o, f3, f7, c, zero, 1'b0), c);
    end
  endtask

  initial begin
    logic [6:0] legal_ops [6];
    logic [6:0] o;
    int ab;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      zero = 1'($urandom_range(0, 1));
      push(model(op, funct3, funct7b5, 0, zero, 1'b1), 0);
    end

    // directed
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 0);   // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 2, 0);   // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 2, 0);   // sub
    run_instr(7'b0110011, 3'b000, 1'b0, 2, 0);   // add
    run_instr(7'b0010011, 3'b000, 1'b1, 2, 0);   // addi, instr[30] ignored
    run_instr(7'b0110011, 3'b111, 1'b0, 2, 0);   // and
    run_instr(7'b0110011, 3'b110, 1'b0, 2, 0);   // or
    run_instr(7'b0010011, 3'b010, 1'b0, 2, 0);   // slti
    run_instr(7'b1100011, 3'b000, 1'b0, 1, 0);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);   // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 2, 0);   // jal
    run_instr(7'b0000000, 3'b000, 1'b0, 2, 0);   // illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 4);   // lw aborted in MEMREAD
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 0);

    // random
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 7'($urandom); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 5)];
      end
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(1, n_cycles(o)) : 0;
      run_instr(o, 3'($urandom), 1'($urandom), 2, ab);
    end

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
